serial_in: RTL

SERIAL_IN -- requirements
Module: serial_in

---
 rtl/serial_in.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serial_in.sv
// Serial-to-parallel receiver: assembles LSB-first words into a 2-entry output buffer
// whose head word and valid flag come straight from registers.
module serial_in #(
   parameter int WIDTH   = 32,
   parameter int COUNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin_data,
   input  logic             sin_valid,
   output logic             rx_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             frame_err,
   output logic             overflow,
   output logic [15:0]      word_cnt
);

   typedef enum logic {S_IDLE, S_RECV} state_t;

   localparam logic [COUNT_W-1:0] LAST_BIT = COUNT_W'(WIDTH - 1);

   state_t             r_state, w_state_next;
   logic [COUNT_W-1:0] r_cnt, w_cnt_next;
   logic [WIDTH-1:0]   r_shift, w_shift_next;
   logic               w_push_req;
   logic               w_abort;

   logic [WIDTH-1:0]   r_head, r_tail;
   logic               r_head_valid, r_tail_valid;
   logic               r_frame_err, r_overflow;
   logic [15:0]        r_word_cnt;

   logic               w_pop, w_full, w_push, w_drop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_shift <= w_shift_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_shift_next = r_shift;
      w_push_req   = 1'b0;
      w_abort      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (sin_valid) begin
               w_shift_next = {{(WIDTH-1){1'b0}}, sin_data};
               w_cnt_next   = COUNT_W'(1);
               w_state_next = S_RECV;
            end
         end
         S_RECV: begin
            if (sin_valid) begin
               w_shift_next[r_cnt] = sin_data;
               w_cnt_next          = r_cnt + COUNT_W'(1);
               if (r_cnt == LAST_BIT) begin
                  w_push_req   = 1'b1;
                  w_cnt_next   = '0;
                  w_state_next = S_IDLE;
               end
            end else begin
               w_abort      = 1'b1;
               w_cnt_next   = '0;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // A full buffer still takes a new word when the head leaves on the same cycle.
   assign w_pop  = r_head_valid & out_ready;
   assign w_full = r_head_valid & r_tail_valid;
   assign w_push = w_push_req & (~w_full | w_pop);
   assign w_drop = w_push_req & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head       <= '0;
         r_tail       <= '0;
         r_head_valid <= 1'b0;
         r_tail_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overflow   <= 1'b0;
         r_word_cnt   <= '0;
      end else begin
         r_frame_err <= w_abort;
         if (w_drop) r_overflow <= 1'b1;
         if (w_push) r_word_cnt <= r_word_cnt + 16'd1;
         case ({w_push, w_pop})
            2'b10: begin
               if (!r_head_valid) begin
                  r_head       <= w_shift_next;
                  r_head_valid <= 1'b1;
               end else begin
                  r_tail       <= w_shift_next;
                  r_tail_valid <= 1'b1;
               end
            end
            2'b01: begin
               r_head       <= r_tail;
               r_head_valid <= r_tail_valid;
               r_tail       <= '0;
               r_tail_valid <= 1'b0;
            end
            2'b11: begin
               if (r_tail_valid) begin
                  r_head <= r_tail;
                  r_tail <= w_shift_next;
               end else begin
                  r_head <= w_shift_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign rx_ready  = (r_state == S_IDLE) & ~w_full;
   assign out_data  = r_head;
   assign out_valid = r_head_valid;
   assign frame_err = r_frame_err;
   assign overflow  = r_overflow;
   assign word_cnt  = r_word_cnt;

endmodule
